// File: rtl/mem_unit_pkg.sv
// Shared types and constants for the load/store access unit.
package mem_unit_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        RSVD = 2'b11
    } mem_size_t;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RMW_RD,
        RMW_WR,
        RESP
    } mem_state_t;

    localparam int WORD_BYTES = 4;
    localparam int LANE_W     = $clog2(WORD_BYTES);

endpackage

// File: rtl/subword_align.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
import mem_unit_pkg::*;

module subword_align (
    input  logic [31:0]       old_word,
    input  logic [31:0]       new_data,
    input  mem_size_t         size,
    input  logic [LANE_W-1:0] lane,
    input  logic              is_signed,
    output logic [31:0]       load_val,
    output logic [31:0]       merged
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign byte_s = old_word[{lane, 3'b000} +: 8];
    assign half_s = old_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_val = old_word;
        merged   = new_data;
        case (size)
            BYTE: begin
                load_val = is_signed ? {{24{byte_s[7]}}, byte_s} : {24'b0, byte_s};
                merged   = old_word;
                merged[{lane, 3'b000} +: 8] = new_data[7:0];
            end
            HALF: begin
                load_val = is_signed ? {{16{half_s[15]}}, half_s} : {16'b0, half_s};
                merged   = old_word;
                merged[{lane[1], 4'b0000} +: 16] = new_data[15:0];
            end
            default: begin
                load_val = old_word;
                merged   = new_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store controller in front of a word-addressed data memory.
import mem_unit_pkg::*;

module mem_access_unit #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dm_enable,
    output logic        dm_read,
    output logic        dm_write,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    mem_state_t  state_q, state_d;
    logic [31:0] addr_q, wdata_q, old_q, rdata_q;
    mem_size_t   size_q, req_sz;
    logic        write_q, signed_q, err_q;
    logic        req_err, out_of_range;
    logic [31:0] align_old, load_val, merged;

    assign req_sz       = mem_size_t'(req_size);
    // DEPTH is a power of two, so any word-index bit at or above log2(DEPTH) is out of range
    assign out_of_range = |(req_addr[31:2] >> $clog2(DEPTH));
    assign req_err      = (req_sz == RSVD)
                        || (req_sz == HALF && req_addr[0])
                        || (req_sz == WORD && req_addr[1:0] != 2'b00)
                        || out_of_range;

    assign align_old = (state_q == RMW_WR) ? old_q : dm_rdata;

    subword_align u_align (
        .old_word (align_old),
        .new_data (wdata_q),
        .size     (size_q),
        .lane     (addr_q[LANE_W-1:0]),
        .is_signed(signed_q),
        .load_val (load_val),
        .merged   (merged)
    );

    always_comb begin
        state_d   = state_q;
        dm_enable = 1'b0;
        dm_read   = 1'b0;
        dm_write  = 1'b0;
        dm_addr   = 32'b0;
        dm_wdata  = 32'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_d = RESP;
                    else if (req_write && req_sz != WORD)
                        state_d = RMW_RD;
                    else
                        state_d = ACCESS;
                end
            end
            ACCESS: begin
                dm_enable = 1'b1;
                dm_read   = ~write_q;
                dm_write  = write_q;
                dm_addr   = {2'b00, addr_q[31:2]};
                dm_wdata  = write_q ? wdata_q : 32'b0;
                state_d   = RESP;
            end
            RMW_RD: begin
                dm_enable = 1'b1;
                dm_read   = 1'b1;
                dm_addr   = {2'b00, addr_q[31:2]};
                state_d   = RMW_WR;
            end
            RMW_WR: begin
                dm_enable = 1'b1;
                dm_write  = 1'b1;
                dm_addr   = {2'b00, addr_q[31:2]};
                dm_wdata  = merged;
                state_d   = RESP;
            end
            RESP: begin
                if (resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= 32'b0;
            size_q   <= BYTE;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            wdata_q  <= 32'b0;
            old_q    <= 32'b0;
            rdata_q  <= 32'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                addr_q   <= req_addr;
                size_q   <= req_sz;
                write_q  <= req_write;
                signed_q <= req_signed;
                wdata_q  <= req_wdata;
                err_q    <= req_err;
                rdata_q  <= 32'b0;
            end
            if (state_q == ACCESS && !write_q)
                rdata_q <= load_val;
            if (state_q == RMW_RD)
                old_q <= dm_rdata;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
